// File: rtl/pac_pkg.sv
// Shared heading and state encodings for the pac-man motion controller.
package pac_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MOVE    = 2'b01,
        ST_BLOCKED = 2'b10
    } state_e;

endpackage

// File: rtl/pac_tick_gen.sv
// Move-tick generator: one-cycle tick every TICK_DIV cycles, frozen while pause_i is high.
module pac_tick_gen #(
    parameter int TICK_DIV = 1000000
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic pause_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!pause_i) begin
            cnt_d = (cnt_q == TC) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == TC) && !pause_i;

endmodule

// File: rtl/pac_motion.sv
// Pac-man position controller: latches direction requests, steps on move ticks, clamps at bounds.
// Define PAC_WRAP_EN to wrap horizontally instead of clamping at the left/right bounds.
//
// state      | meaning
// ST_IDLE    | no heading accepted yet, position held
// ST_MOVE    | stepping in dir every move tick
// ST_BLOCKED | reached a bound in the current heading, waiting for a new request
module pac_motion
    import pac_pkg::*;
#(
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 479,
    parameter int X_START  = 300,
    parameter int Y_START  = 200,
    parameter int STEP     = 1,
    parameter int TICK_DIV = 1000000
) (
    input  logic           clk_i,
    input  logic           clr_i,
    input  logic           up_i,
    input  logic           down_i,
    input  logic           left_i,
    input  logic           right_i,
    input  logic           pause_i,
    output logic [X_W-1:0] pac_h_o,
    output logic [Y_W-1:0] pac_v_o,
    output logic [1:0]     dir_o,
    output logic           moving_o,
    output logic           step_pulse_o
);

    localparam logic [X_W:0] X_MAX_E  = (X_W+1)'(X_MAX);
    localparam logic [X_W:0] X_LO_E   = (X_W+1)'(X_MIN + STEP);
    localparam logic [X_W:0] X_STEP_E = (X_W+1)'(STEP);
    localparam logic [Y_W:0] Y_MAX_E  = (Y_W+1)'(Y_MAX);
    localparam logic [Y_W:0] Y_LO_E   = (Y_W+1)'(Y_MIN + STEP);
    localparam logic [Y_W:0] Y_STEP_E = (Y_W+1)'(STEP);

    state_e         state_q, state_d;
    dir_e           dir_q, dir_d;
    dir_e           pend_dir_q, pend_dir_d;
    logic           pend_vld_q, pend_vld_d;
    logic [X_W-1:0] pac_h_q, pac_h_d;
    logic [Y_W-1:0] pac_v_q, pac_v_d;
    logic           step_pulse_q, step_pulse_d;

    logic           tick;
    logic           go;
    dir_e           head;
    logic [X_W:0]   h_inc, h_dec;
    logic [Y_W:0]   v_inc, v_dec;

    pac_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i   (clk_i),
        .clr_i   (clr_i),
        .pause_i (pause_i),
        .tick_o  (tick)
    );

    // Extended-width sums so overflow/underflow is detected instead of wrapping.
    assign h_inc = {1'b0, pac_h_q} + X_STEP_E;
    assign h_dec = {1'b0, pac_h_q} - X_STEP_E;
    assign v_inc = {1'b0, pac_v_q} + Y_STEP_E;
    assign v_dec = {1'b0, pac_v_q} - Y_STEP_E;

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        pend_dir_d = pend_dir_q;
        pend_vld_d = pend_vld_q;
        pac_h_d    = pac_h_q;
        pac_v_d    = pac_v_q;
        go         = 1'b0;
        head       = dir_q;

        if (tick) begin
            if (pend_vld_q) begin
                go         = 1'b1;
                head       = pend_dir_q;
                pend_vld_d = 1'b0;
            end else if (state_q == ST_MOVE) begin
                go = 1'b1;
            end
        end

        if (go) begin
            dir_d   = head;
            state_d = ST_MOVE;
            unique case (head)
                DIR_UP: begin
                    if (v_inc < Y_LO_E + Y_STEP_E) begin
                        pac_v_d = Y_W'(Y_MIN);
                        state_d = ST_BLOCKED;
                    end else begin
                        pac_v_d = Y_W'(v_dec);
                    end
                end
                DIR_DOWN: begin
                    if (v_inc > Y_MAX_E) begin
                        pac_v_d = Y_W'(Y_MAX);
                        state_d = ST_BLOCKED;
                    end else begin
                        pac_v_d = Y_W'(v_inc);
                    end
                end
                DIR_LEFT: begin
                    if (h_inc < X_LO_E + X_STEP_E) begin
`ifdef PAC_WRAP_EN
                        pac_h_d = X_W'(X_MAX);
`else
                        pac_h_d = X_W'(X_MIN);
                        state_d = ST_BLOCKED;
`endif
                    end else begin
                        pac_h_d = X_W'(h_dec);
                    end
                end
                DIR_RIGHT: begin
                    if (h_inc > X_MAX_E) begin
`ifdef PAC_WRAP_EN
                        pac_h_d = X_W'(X_MIN);
`else
                        pac_h_d = X_W'(X_MAX);
                        state_d = ST_BLOCKED;
`endif
                    end else begin
                        pac_h_d = X_W'(h_inc);
                    end
                end
                default: ;
            endcase
        end

        // A fresh request lands after consumption so it is kept for the next tick.
        if (up_i || down_i || left_i || right_i) begin
            pend_vld_d = 1'b1;
            if (up_i)        pend_dir_d = DIR_UP;
            else if (down_i) pend_dir_d = DIR_DOWN;
            else if (left_i) pend_dir_d = DIR_LEFT;
            else             pend_dir_d = DIR_RIGHT;
        end

        step_pulse_d = (pac_h_d != pac_h_q) || (pac_v_d != pac_v_q);
    end

    always_ff @(posedge clk_i) begin
        if (!clr_i) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_LEFT;
            pend_dir_q   <= DIR_UP;
            pend_vld_q   <= 1'b0;
            pac_h_q      <= X_W'(X_START);
            pac_v_q      <= Y_W'(Y_START);
            step_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            pend_dir_q   <= pend_dir_d;
            pend_vld_q   <= pend_vld_d;
            pac_h_q      <= pac_h_d;
            pac_v_q      <= pac_v_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign pac_h_o      = pac_h_q;
    assign pac_v_o      = pac_v_q;
    assign dir_o        = dir_q;
    assign moving_o     = (state_q == ST_MOVE);
    assign step_pulse_o = step_pulse_q;

endmodule

// File: tb/tb_pac_motion.sv
// Directed bench for pac_motion with TICK_DIV=4, STEP=2; honours PAC_WRAP_EN for the right-bound case.
module tb_pac_motion;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, pause = 1'b0;
    logic [9:0] pac_h;
    logic [9:0] pac_v;
    logic [1:0] dir;
    logic       moving;
    logic       step_pulse;

    int n_cmp = 0;
    int n_err = 0;
    int cnt_m = 0;
    bit hit   = 1'b0;

    always #5 clk = ~clk;

    pac_motion #(
        .TICK_DIV (4),
        .STEP     (2)
    ) dut (
        .clk_i        (clk),
        .clr_i        (clr),
        .up_i         (up),
        .down_i       (down),
        .left_i       (left),
        .right_i      (right),
        .pause_i      (pause),
        .pac_h_o      (pac_h),
        .pac_v_o      (pac_v),
        .dir_o        (dir),
        .moving_o     (moving),
        .step_pulse_o (step_pulse)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; the bench keeps its own model of the tick counter to know where ticks land.
    task automatic cyc();
        int old;
        old = cnt_m;
        @(posedge clk);
        if (!clr)        cnt_m = 0;
        else if (!pause) cnt_m = (old == 3) ? 0 : old + 1;
        hit = clr && !pause && (old == 3);
        @(negedge clk);
    endtask

    task automatic next_tick();
        int n;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 64) begin
            cyc();
            n++;
        end
        if (!hit) chk("tick_timeout", 0, 1);
    endtask

    initial begin
        @(negedge clk);
        cyc();
        cyc();
        chk("rst_h", pac_h, 300);
        chk("rst_v", pac_v, 200);
        chk("rst_dir", dir, 2);
        chk("rst_moving", moving, 0);
        chk("rst_step", step_pulse, 0);
        clr = 1'b1;

        right = 1'b1; cyc(); right = 1'b0;
        next_tick();
        chk("r1_h", pac_h, 302);
        chk("r1_moving", moving, 1);
        chk("r1_dir", dir, 3);
        chk("r1_step", step_pulse, 1);
        cyc();
        chk("r1_step_low", step_pulse, 0);
        next_tick();
        chk("r2_h", pac_h, 304);
        next_tick();
        chk("r3_h", pac_h, 306);

        up = 1'b1; left = 1'b1; cyc(); up = 1'b0; left = 1'b0;
        next_tick();
        chk("ul_dir", dir, 0);
        chk("ul_v", pac_v, 198);
        chk("ul_h", pac_h, 306);

        pause = 1'b1;
        down  = 1'b1; cyc(); down = 1'b0;
        repeat (39) cyc();
        chk("pause_v", pac_v, 198);
        chk("pause_h", pac_h, 306);
        chk("pause_dir", dir, 0);
        chk("pause_step", step_pulse, 0);
        pause = 1'b0;
        next_tick();
        chk("unpause_v", pac_v, 200);
        chk("unpause_dir", dir, 1);
        chk("unpause_step", step_pulse, 1);

        right = 1'b1; cyc(); right = 1'b0;
        next_tick();
        chk("run_h", pac_h, 308);
        chk("run_v", pac_v, 200);
        repeat (165) next_tick();
        chk("edge_h", pac_h, 638);
        next_tick();
`ifdef PAC_WRAP_EN
        chk("wrap_h", pac_h, 0);
        chk("wrap_moving", moving, 1);
        chk("wrap_step", step_pulse, 1);
        next_tick();
        chk("wrap_next_h", pac_h, 2);
`else
        chk("clamp_h", pac_h, 639);
        chk("clamp_moving", moving, 0);
        chk("clamp_step", step_pulse, 1);
        next_tick();
        chk("blocked_h", pac_h, 639);
        chk("blocked_step", step_pulse, 0);
        right = 1'b1; cyc(); right = 1'b0;
        next_tick();
        chk("blocked_same_h", pac_h, 639);
        chk("blocked_same_moving", moving, 0);
        left = 1'b1; cyc(); left = 1'b0;
        next_tick();
        chk("unblock_h", pac_h, 637);
        chk("unblock_moving", moving, 1);
`endif

        clr = 1'b0; cyc(); cyc(); clr = 1'b1;
        right = 1'b1; cyc(); right = 1'b0;
        repeat (5) next_tick();
        chk("pre_rst_h", pac_h, 310);
        clr = 1'b0; cyc(); clr = 1'b1;
        chk("mid_rst_h", pac_h, 300);
        chk("mid_rst_moving", moving, 0);
        chk("mid_rst_dir", dir, 2);
        repeat (3) next_tick();
        chk("idle_h", pac_h, 300);
        chk("idle_v", pac_v, 200);
        down = 1'b1; cyc(); down = 1'b0;
        next_tick();
        chk("post_rst_v", pac_v, 202);
        chk("post_rst_dir", dir, 1);
        chk("post_rst_moving", moving, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pac_motion.md
PAC_MOTION -- requirements
Module: pac_motion

Interface
REQ-001 Parameter X_W, 10, pac_h width in bits.
REQ-002 Parameter Y_W, 10, pac_v width in bits.
REQ-003 Parameters X_MIN/X_MAX, 0/639, horizontal bounds (inclusive).
REQ-004 Parameters Y_MIN/Y_MAX, 0/479, vertical bounds (inclusive).
REQ-005 Parameters X_START/Y_START, 300/200, reset position.
REQ-006 Parameter STEP, 1, pixels moved per move tick.
REQ-007 Parameter TICK_DIV, 1000000, clk cycles per move tick (>=2).
REQ-008 clk  in  1  single system clock; all logic on rising edge.
REQ-009 clr  in  1  reset, synchronous, active-low.
REQ-010 up, down, left, right  in  1 each  direction requests, level, debounced upstream.
REQ-011 pause  in  1  freezes the move tick and movement while high.
REQ-012 pac_h  out  X_W  horizontal position.
REQ-013 pac_v  out  Y_W  vertical position; up decreases pac_v.
REQ-014 dir  out  2  current heading: 00 up, 01 down, 10 left, 11 right.
REQ-015 moving  out  1  high while state is MOVE.
REQ-016 step_pulse  out  1  one-cycle pulse in the cycle after a position change.

Function
REQ-017 States: IDLE (no heading accepted yet), MOVE, BLOCKED (at a bound in heading).
REQ-018 Any cycle with a request asserted loads pending request; priority up > down > left > right; later requests overwrite earlier unconsumed ones.
REQ-019 Move tick pulses for one cycle when tick counter reaches TICK_DIV-1; counter then returns to 0.
REQ-020 On a tick with a valid pending request: dir takes pending value, pending cleared, state to MOVE, step applied in new heading on the same tick.
REQ-021 On a tick in MOVE without pending request: step in current dir; pac-man keeps moving with no input held.
REQ-022 Position update visible one cycle after the tick cycle; step_pulse high in that cycle only when pac_h or pac_v changed.
REQ-023 Step arithmetic in width+1 bits; no wrap from unsigned overflow/underflow.
REQ-024 Right: if pac_h+STEP > X_MAX then pac_h = X_MAX, state BLOCKED; left: if pac_h < X_MIN+STEP then pac_h = X_MIN, BLOCKED; same rule for up/down against Y_MIN/Y_MAX.
REQ-025 Clamping step that still changes position pulses step_pulse; subsequent ticks in BLOCKED do not move.
REQ-026 BLOCKED: pending request in a different heading leaves BLOCKED per REQ-020; request in the blocked heading keeps BLOCKED, position unchanged.
REQ-027 IDLE: no movement until first pending request is consumed.
REQ-028 pause high: tick counter holds value, no ticks, no movement; requests still latched and applied at first tick after release.

Reset
REQ-029 clr low at a rising edge: pac_h=X_START, pac_v=Y_START, dir=10 (left), state IDLE, moving=0, step_pulse=0, pending cleared, tick counter 0.
REQ-030 Reset overrides a coincident tick or request; mid-movement reset restores REQ-029 values on next cycle.

Configuration
REQ-031 Macro PAC_WRAP_EN defined: horizontal step past X_MAX sets pac_h = X_MIN (past X_MIN sets X_MAX), state remains MOVE, step_pulse pulses; vertical still clamps.
REQ-032 PAC_WRAP_EN undefined: all four bounds clamp per REQ-024.

Structure
REQ-033 Package pac_pkg holds direction encoding typedef (UP/DOWN/LEFT/RIGHT) and state enum.
REQ-034 Sub-module pac_tick_gen (parameter TICK_DIV, inputs clk/clr/pause, output tick) implements the move tick.

Verification (bench uses TICK_DIV=4, STEP=2)
REQ-035 clr low 2 cycles -> pac_h=300, pac_v=200, dir=10, moving=0, step_pulse=0.
REQ-036 right pulsed 1 cycle -> next tick pac_h=302, moving=1; following ticks 304, 306 with no input.
REQ-037 up and left asserted same cycle -> dir=00, pac_v 200->198, pac_h unchanged.
REQ-038 pac_h=638 heading right -> pac_h=639, moving=0, next tick no change; with PAC_WRAP_EN pac_h=0, moving=1.
REQ-039 pause high 10 tick periods with down requested -> no change; first tick after release pac_v +2, dir=01.
REQ-040 clr low mid-move at pac_h=310 -> next cycle pac_h=300, state IDLE, no movement until new request.
